// File: rtl/load_ext_ctrl_if.sv
// Request/response and memory-read signal bundle for load_ext_ctrl.
// slave is the controller's view; master is the requester/memory side.
interface load_ext_ctrl_if;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          start;
    logic [AW-1:0] addr;
    logic [1:0]    size;
    logic          sext;
    logic          busy;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ready;
    logic [DW-1:0] mem_rdata;
    logic          done;
    logic [DW-1:0] rdata;
    logic          err;

    modport slave (
        input  start, addr, size, sext, mem_ready, mem_rdata,
        output busy, mem_req, mem_addr, done, rdata, err
    );

    modport master (
        output start, addr, size, sext, mem_ready, mem_rdata,
        input  busy, mem_req, mem_addr, done, rdata, err
    );
endinterface

// File: rtl/load_ext_ctrl.sv
// Load controller: one aligned word read, lane select and sign/zero extension.
// Define LOAD_MISALIGN_CHK_EN to reject misaligned halfword/word loads up front.
module load_ext_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    load_ext_ctrl_if.slave   bus
);
    localparam int unsigned CW = 8;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, WAIT, EXT, DONE} state_t;

    state_t          state;
    state_t          state_n;
    logic [CW-1:0]   cnt;
    logic [1:0]      size_q;
    logic [1:0]      ofs_q;
    logic            sext_q;
    logic [DW-1:0]   word_q;

    logic            misalign_c;
    logic            reject_c;
    logic            timeout_c;
    logic            fail_c;
    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [DW-1:0]   ext_c;

`ifdef LOAD_MISALIGN_CHK_EN
    assign misalign_c = ((bus.size == 2'b01) && bus.addr[0]) ||
                        ((bus.size == 2'b10) && (bus.addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    assign reject_c  = (bus.size == 2'b11) || misalign_c;
    assign timeout_c = (TIMEOUT_CYC != 0) && (cnt == CW'(TIMEOUT_CYC));

    // Little-endian lane selection from the captured word
    assign byte_c = word_q[{ofs_q, 3'b000} +: 8];
    assign half_c = ofs_q[1] ? word_q[31:16] : word_q[15:0];

    always_comb begin
        ext_c = word_q;
        case (size_q)
            2'b00:   ext_c = {{24{sext_q & byte_c[7]}}, byte_c};
            2'b01:   ext_c = {{16{sext_q & half_c[15]}}, half_c};
            default: ext_c = word_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // mem_ready beats the timeout when both land in the same cycle
    always_comb begin
        state_n = state;
        fail_c  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (reject_c) begin
                        state_n = DONE;
                        fail_c  = 1'b1;
                    end else begin
                        state_n = WAIT;
                    end
                end
            end
            WAIT: begin
                if (bus.mem_ready) begin
                    state_n = EXT;
                end else if (timeout_c) begin
                    state_n = DONE;
                    fail_c  = 1'b1;
                end
            end
            EXT:     state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with it
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.busy     <= 1'b0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
            bus.rdata    <= '0;
            cnt          <= '0;
            size_q       <= '0;
            ofs_q        <= '0;
            sext_q       <= 1'b0;
            word_q       <= '0;
        end else begin
            bus.busy    <= (state_n != IDLE);
            bus.mem_req <= (state_n == WAIT);
            bus.done    <= (state_n == DONE);
            bus.err     <= fail_c;
            cnt         <= (state_n == WAIT) ? cnt + CW'(1) : '0;

            if ((state == IDLE) && bus.start) begin
                size_q       <= bus.size;
                sext_q       <= bus.sext;
                ofs_q        <= bus.addr[1:0];
                bus.mem_addr <= {bus.addr[31:2], 2'b00};
            end

            if ((state == WAIT) && bus.mem_ready) begin
                word_q <= bus.mem_rdata;
            end

            if (state_n == DONE) begin
                bus.rdata <= fail_c ? '0 : ext_c;
            end
        end
    end
endmodule

// File: tb/tb_load_ext_ctrl.sv
// Self-checking bench for load_ext_ctrl: transaction-level model fills
// per-cycle expectation arrays; a negedge process compares every cycle.
module tb_load_ext_ctrl;
    localparam int unsigned TO = 4;
    localparam int NC = 400;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    bit   run = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;

    bit          eb  [NC];
    bit          emq [NC];
    bit          ed  [NC];
    bit          ee  [NC];
    logic [31:0] er  [NC];
    logic [31:0] ema [NC];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    load_ext_ctrl_if bus();

    load_ext_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load result from the word, byte address, size and sign flag
    function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [31:0] a,
                                              input logic [1:0] sz, input logic sx);
        int nbits;
        int sh;
        logic [63:0] v;
        logic [63:0] m;
        nbits = 8 << sz;
        sh = (sz == 2'b00) ? 8 * int'(a[1:0]) : (sz == 2'b01) ? 16 * int'(a[1]) : 0;
        v = 64'(w >> sh);
        m = (64'd1 << nbits) - 64'd1;
        v = v & m;
        if (sx && nbits < 32 && v[nbits-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // Schedule the expected outputs of a load started in cycle s with
    // mem_ready offered d cycles into WAIT (d<0: never)
    task automatic plan(input int s, input logic [31:0] a, input logic [1:0] sz,
                        input logic sx, input int d, input logic [31:0] w, output int dc);
        bit bad;
        bit ok;
        int nw;
        logic [31:0] res;
        bad = (sz == 2'b11);
`ifdef LOAD_MISALIGN_CHK_EN
        if (sz == 2'b01 && a[0]) bad = 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        ok = 1'b0;
        if (bad) begin
            dc = s + 1;
        end else begin
            ok = (d >= 0) && (TO == 0 || d < int'(TO));
            nw = ok ? d + 1 : int'(TO);
            for (int k = s + 1; k <= s + nw; k++) begin
                emq[k] = 1'b1;
                eb[k]  = 1'b1;
                ema[k] = a & 32'hFFFF_FFFC;
            end
            if (ok) eb[s + nw + 1] = 1'b1;
            dc = s + nw + (ok ? 2 : 1);
        end
        res = ok ? ext_model(w, a, sz, sx) : 32'h0;
        eb[dc] = 1'b1;
        ed[dc] = 1'b1;
        ee[dc] = !ok;
        for (int k = dc; k < NC; k++) er[k] = res;
    endtask

    task automatic model_reset(input int c);
        for (int k = c + 1; k < NC; k++) begin
            eb[k] = 1'b0; emq[k] = 1'b0; ed[k] = 1'b0; ee[k] = 1'b0; er[k] = 32'h0;
        end
    endtask

    // Drive one load; returns in its done cycle (or later if ready came late)
    task automatic do_load(input logic [31:0] a, input logic [1:0] sz, input logic sx,
                           input int d, input logic [31:0] w,
                           output int dc, output logic [31:0] ma);
        int s;
        s = cyc;
        plan(s, a, sz, sx, d, w, dc);
        bus.start = 1'b1; bus.addr = a; bus.size = sz; bus.sext = sx;
        tick();
        ma = bus.mem_addr;
        bus.start = 1'b0; bus.addr = $urandom; bus.size = 2'($urandom); bus.sext = 1'($urandom);
        if (d >= 0) begin
            repeat (d) tick();
            bus.mem_ready = 1'b1; bus.mem_rdata = w;
            tick();
            bus.mem_ready = 1'b0; bus.mem_rdata = $urandom;
        end
        while (cyc < dc) tick();
    endtask

    always @(negedge clk) begin
        if (run && cyc >= 1 && cyc < NC) begin
            chk("busy",    32'(bus.busy),    32'(eb[cyc]));
            chk("mem_req", 32'(bus.mem_req), 32'(emq[cyc]));
            chk("done",    32'(bus.done),    32'(ed[cyc]));
            chk("err",     32'(bus.err),     32'(ee[cyc]));
            chk("rdata",   bus.rdata,        er[cyc]);
            if (emq[cyc]) chk("mem_addr", bus.mem_addr, ema[cyc]);
        end
    end

    initial begin
        int s;
        int dc;
        logic [31:0] ma;
        for (int k = 0; k < NC; k++) begin
            eb[k] = 1'b0; emq[k] = 1'b0; ed[k] = 1'b0; ee[k] = 1'b0;
            er[k] = 32'h0; ema[k] = 32'h0;
        end
        bus.start = 1'b0; bus.addr = '0; bus.size = '0; bus.sext = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        rst = 1'b1;
        run = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        tick();

        s = cyc;
        do_load(32'h0000_1003, 2'b00, 1'b1, 0, 32'h80FF_1234, dc, ma);
        chk("sbyte_lat", 32'(dc - s), 32'd3);
        chk("sbyte_maddr", ma, 32'h0000_1000);
        chk("sbyte_rdata", bus.rdata, 32'hFFFF_FF80);
        chk("sbyte_done", 32'(bus.done), 32'h1);
        chk("sbyte_err", 32'(bus.err), 32'h0);
        tick();

        do_load(32'h0000_2002, 2'b01, 1'b0, 1, 32'h8765_4321, dc, ma);
        chk("half_zx", bus.rdata, 32'h0000_8765);
        tick();
        do_load(32'h0000_2002, 2'b01, 1'b1, 2, 32'h8765_4321, dc, ma);
        chk("half_sx", bus.rdata, 32'hFFFF_8765);
        tick();

        for (int i = 0; i < 4; i++) begin
            do_load(32'h40 + 32'(i), 2'b00, 1'(i), 0, 32'h80FF_1234, dc, ma);
            tick();
        end

        do_load(32'h0000_0050, 2'b10, 1'b1, 0, 32'h8000_0001, dc, ma);
        chk("word", bus.rdata, 32'h8000_0001);
        tick();
        do_load(32'h0000_0060, 2'b01, 1'b1, 0, 32'h1234_8000, dc, ma);
        chk("half0_sx", bus.rdata, 32'hFFFF_8000);
        tick();

        s = cyc;
        do_load(32'h0000_8004, 2'b10, 1'b0, -1, 32'h0, dc, ma);
        chk("tmo_lat", 32'(dc - s), 32'd5);
        chk("tmo_err", 32'(bus.err), 32'h1);
        chk("tmo_rdata", bus.rdata, 32'h0);
        tick();

        s = cyc;
`ifdef LOAD_MISALIGN_CHK_EN
        do_load(32'h0000_1001, 2'b01, 1'b0, -1, 32'h8765_4321, dc, ma);
        chk("mis_lat", 32'(dc - s), 32'd1);
        chk("mis_err", 32'(bus.err), 32'h1);
`else
        do_load(32'h0000_1001, 2'b01, 1'b0, 0, 32'h8765_4321, dc, ma);
        chk("mis_lane0", bus.rdata, 32'h0000_4321);
        chk("mis_err", 32'(bus.err), 32'h0);
`endif
        tick();
        do_load(32'h0000_1002, 2'b10, 1'b0, 0, 32'hA5A5_5A5A, dc, ma);
        tick();

        s = cyc;
        do_load(32'h0000_7000, 2'b11, 1'b1, -1, 32'h0, dc, ma);
        chk("rsv_lat", 32'(dc - s), 32'd1);
        chk("rsv_err", 32'(bus.err), 32'h1);
        chk("rsv_rdata", bus.rdata, 32'h0);
        tick();

        s = cyc;
        do_load(32'h0000_9000, 2'b10, 1'b0, int'(TO) - 1, 32'hCAFE_F00D, dc, ma);
        chk("late_rdy_lat", 32'(dc - s), 32'd6);
        chk("late_rdy", bus.rdata, 32'hCAFE_F00D);
        tick();
        do_load(32'h0000_9100, 2'b10, 1'b0, int'(TO), 32'h1111_2222, dc, ma);
        tick();

        // start held during the DONE cycle must not launch a load
        do_load(32'h0000_A001, 2'b00, 1'b0, 0, 32'h0000_5500, dc, ma);
        chk("byte1", bus.rdata, 32'h0000_0055);
        bus.start = 1'b1; bus.size = 2'b00;
        tick();
        bus.start = 1'b0;
        tick();
        chk("done_start_ign", 32'(bus.busy), 32'h0);
        tick();

        // reset in the second WAIT cycle, with a repeated start while busy
        s = cyc;
        plan(s, 32'h0000_3000, 2'b10, 1'b0, -1, 32'h0, dc);
        bus.start = 1'b1; bus.addr = 32'h0000_3000; bus.size = 2'b10; bus.sext = 1'b0;
        tick();
        bus.addr = 32'h0000_3100;
        tick();
        bus.start = 1'b0;
        rst = 1'b1;
        model_reset(cyc);
        tick();
        rst = 1'b0;
        chk("rst_wait_busy", 32'(bus.busy), 32'h0);
        chk("rst_wait_req", 32'(bus.mem_req), 32'h0);
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ready = 1'b0;
        repeat (6) tick();

        do_load(32'h0000_B002, 2'b00, 1'b1, 0, 32'h007F_0000, dc, ma);
        chk("post_rst", bus.rdata, 32'h0000_007F);
        repeat (3) tick();

        run = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
